// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 device-to-host receiver that folds E0/F0 prefixes into one 16-bit scan word with a one-cycle strobe in bit 15.
module ps2_rx_ctrl #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  input  logic        enable,
  output logic [15:0] code_word,
  output logic        code_valid,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE} state_t;
  state_t        r_state;
  logic [1:0]    r_s1, r_s2, r_filt;
  logic [7:0]    r_fcnt [2];
  logic          r_clk_prev, r_fall;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_byte;
  logic          r_par, r_frame_ok, r_par_ok, r_pend_ext, r_pend_brk, r_valid;
  logic [14:0]   r_word;
  logic [TW-1:0] r_to_cnt;
  logic          w_dat, w_in_frame, w_timeout;
  assign w_dat      = r_filt[0];
  assign w_in_frame = r_state inside {DATA, PARITY, STOP};
  assign w_timeout  = w_in_frame && r_to_cnt == TW'(TIMEOUT_CYC - 1);
  assign code_word  = {r_valid, r_word};
  assign code_valid = r_valid;
  assign busy       = r_state != IDLE;
  // bit 1 carries ps2_clk, bit 0 carries ps2_dat; both idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1       <= 2'b11;
      r_s2       <= 2'b11;
      r_filt     <= 2'b11;
      r_clk_prev <= 1'b1;
      r_fall     <= 1'b0;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_s1       <= {ps2_clk, ps2_dat};
      r_s2       <= r_s1;
      r_clk_prev <= r_filt[1];
      r_fall     <= r_clk_prev & ~r_filt[1];
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) r_fcnt[i] <= '0;
        else if (r_fcnt[i] == 8'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else r_fcnt[i] <= r_fcnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_byte     <= '0;
      r_par      <= 1'b0;
      r_frame_ok <= 1'b0;
      r_par_ok   <= 1'b0;
      r_pend_ext <= 1'b0;
      r_pend_brk <= 1'b0;
      r_valid    <= 1'b0;
      r_word     <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_valid  <= 1'b0;
      // counts cycles since the last frame fall, so the abort lands TIMEOUT_CYC cycles after it
      r_to_cnt <= (r_fall && (w_in_frame || (r_state == IDLE && !w_dat))) ? TW'(1) :
                  w_in_frame ? r_to_cnt + 1'b1 : '0;
      if (!enable) begin
        r_state    <= IDLE;
        r_bit_cnt  <= '0;
        r_pend_ext <= 1'b0;
        r_pend_brk <= 1'b0;
        r_to_cnt   <= '0;
      end else if (w_timeout) begin
        r_state    <= IDLE;
        r_valid    <= 1'b1;
        r_word     <= {3'b0, 1'b1, 1'b0, r_pend_ext, r_pend_brk, 8'h00};
        r_pend_ext <= 1'b0;
        r_pend_brk <= 1'b0;
        r_to_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: if (r_fall && !w_dat) begin
            r_state   <= DATA;
            r_bit_cnt <= '0;
          end
          DATA: if (r_fall) begin
            r_byte    <= {w_dat, r_byte[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: if (r_fall) begin
            r_par   <= w_dat;
            r_state <= STOP;
          end
          STOP: if (r_fall) begin
            r_frame_ok <= w_dat;
            r_par_ok   <= ^{r_byte, r_par};
            r_state    <= DONE;
          end
          default: begin
            r_state <= IDLE;
            if (!r_par_ok || !r_frame_ok || (r_byte != 8'hE0 && r_byte != 8'hF0)) begin
              r_valid    <= 1'b1;
              r_word     <= {3'b0, !r_frame_ok, !r_par_ok, r_pend_ext, r_pend_brk, r_byte};
              r_pend_ext <= 1'b0;
              r_pend_brk <= 1'b0;
            end else if (r_byte == 8'hE0) r_pend_ext <= 1'b1;
            else r_pend_brk <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb_ps2_rx_ctrl: directed bench for ps2_rx_ctrl; a 1.25 us system clock makes an 80-cycle PS/2 bit a 10 kHz PS/2 clock.
`timescale 1ns/1ps
module tb_ps2_rx_ctrl;
  localparam int FL = 8;
  localparam int TO = 1000;
  // pin fall -> 2 sync flops -> FILTER_LEN filter -> registered fall (cycle N) -> DONE (N+1) -> strobe (N+2)
  localparam int LAT  = 2 + FL + 1 + 2;
  localparam int TLAT = 2 + FL + 1 + TO;
  logic        clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1, enable = 1'b1;
  logic [15:0] code_word;
  logic        code_valid, busy;
  int          cyc = 0, npulse = 0, pcyc = 0, last_fall = 0, n_pass = 0, n_tot = 0, base = 0;
  logic [15:0] pw = '0;
  logic        pb_now = 1'b0, pb_prev = 1'b0, busy_d = 1'b0, busy_seen = 1'b0;
  ps2_rx_ctrl #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .enable(enable),
    .code_word(code_word), .code_valid(code_valid), .busy(busy)
  );
  always #625 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (code_valid) begin
      npulse++;
      pw      = code_word;
      pcyc    = cyc;
      pb_now  = busy;
      pb_prev = busy_d;
    end
    busy_d = busy;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic waitc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    ps2_dat = b;
    waitc(20);
    ps2_clk = 1'b0;
    last_fall = cyc;
    waitc(40);
    ps2_clk = 1'b1;
    waitc(20);
  endtask
  task automatic send(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
    ps2_dat = 1'b1;
    waitc(30);
  endtask
  function automatic logic [10:0] mkf(input logic [7:0] b, input logic flip, input logic stop);
    return {stop, (~^b) ^ flip, b, 1'b0};
  endfunction
  initial begin
    waitc(3);
    chk("rst_word", code_word, 16'h0000);
    chk("rst_valid", code_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    waitc(10);
    base = npulse;
    send(mkf(8'h1C, 1'b0, 1'b1), 11);
    chk("t1_npulse", npulse - base, 1);
    chk("t1_pulse_word", pw, 16'h801C);
    chk("t1_latency", pcyc - last_fall, LAT);
    chk("t1_hold_word", code_word, 16'h001C);
    chk("t1_valid_low", code_valid, 1'b0);
    chk("t1_busy_low", busy, 1'b0);
    base = npulse;
    send(mkf(8'hF0, 1'b0, 1'b1), 11);
    chk("t2_f0_nopulse", npulse - base, 0);
    send(mkf(8'h1C, 1'b0, 1'b1), 11);
    chk("t2_brk_npulse", npulse - base, 1);
    chk("t2_brk_pulse", pw, 16'h811C);
    chk("t2_brk_hold", code_word, 16'h011C);
    base = npulse;
    send(mkf(8'hE0, 1'b0, 1'b1), 11);
    send(mkf(8'hF0, 1'b0, 1'b1), 11);
    chk("t2_pfx_nopulse", npulse - base, 0);
    send(mkf(8'h75, 1'b0, 1'b1), 11);
    chk("t2_ext_npulse", npulse - base, 1);
    chk("t2_ext_hold", code_word, 16'h0375);
    send(mkf(8'hF0, 1'b0, 1'b1), 11);
    send(mkf(8'h1C, 1'b1, 1'b1), 11);
    chk("t3_parerr", code_word, 16'h051C);
    send(mkf(8'h1C, 1'b0, 1'b1), 11);
    chk("t3_cleared", code_word, 16'h001C);
    send(mkf(8'h1C, 1'b0, 1'b0), 11);
    chk("t3_framerr", code_word, 16'h081C);
    base = npulse;
    send(mkf(8'h1C, 1'b0, 1'b1), 5);
    chk("t4_busy_mid", busy, 1'b1);
    waitc(TO + 100);
    chk("t4_npulse", npulse - base, 1);
    chk("t4_pulse_word", pw, 16'h8800);
    chk("t4_latency", pcyc - last_fall, TLAT);
    chk("t4_busy_at_pulse", pb_now, 1'b0);
    chk("t4_busy_before", pb_prev, 1'b1);
    base = npulse;
    busy_seen = 1'b0;
    ps2_clk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    ps2_clk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    chk("t5_glitch_busy", busy_seen, 1'b0);
    chk("t5_glitch_nopulse", npulse - base, 0);
    send(mkf(8'h1C, 1'b0, 1'b1), 11);
    chk("t5_glitch_after", code_word, 16'h001C);
    chk("t5_glitch_npulse", npulse - base, 1);
    base = npulse;
    send(mkf(8'h1C, 1'b0, 1'b1), 6);
    chk("t5_en_busy_mid", busy, 1'b1);
    enable = 1'b0;
    waitc(1);
    enable = 1'b1;
    chk("t5_en_idle", busy, 1'b0);
    waitc(TO + 100);
    chk("t5_en_nopulse", npulse - base, 0);
    send(mkf(8'h1C, 1'b0, 1'b1), 11);
    chk("t5_en_npulse", npulse - base, 1);
    chk("t5_en_pulse", pw, 16'h801C);
    send(mkf(8'h75, 1'b0, 1'b1), 4);
    chk("t6_busy_mid", busy, 1'b1);
    reset = 1'b1;
    waitc(1);
    chk("t6_word", code_word, 16'h0000);
    chk("t6_valid", code_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    reset = 1'b0;
    waitc(20);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
Receive sequencer for the PS/2 keyboard path. It synchronizes and de-glitches the raw ps2_clk/ps2_dat pins and deserializes 11-bit device-to-host frames. It folds E0 (extended) and F0 (break) prefixes into one 16-bit scan word, which drives the in_port of the PS/2 data PIO. Bit 15 of that word is a one-cycle strobe, so the PIO rising-edge capture on bit 15 flags each new key event to the CPU.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronized samples required before the filtered clk/dat level changes (2..255)
TIMEOUT_CYC, 50000, clk cycles without a filtered ps2_clk falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz)

Ports:
clk  in  1  system clock; the block's only clock
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_dat  in  1  raw PS/2 data pin, asynchronous
enable  in  1  receiver enable; 0 forces IDLE
code_word  out  16  [7:0] code, [8] break, [9] extended, [10] parity_err, [11] frame_err, [14:12] 0, [15] strobe (= code_valid)
code_valid  out  1  one-cycle pulse when code_word[14:0] is updated
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: code_word=0, code_valid=0, busy=0, state=IDLE, pend_ext=pend_brk=0, filtered clk/dat=1, counters=0.
- Synchronizer: 2-flop synchronizer on each pin.
- Filter, per signal: counter restarts whenever the synchronized sample differs from the filtered level. The filtered level takes the new value when FILTER_LEN consecutive differing samples are reached. Glitches shorter than FILTER_LEN cycles are ignored.
- fall = filtered_clk_prev & ~filtered_clk, registered, one cycle wide. Data is sampled from filtered dat in the same cycle.
- FSM states: IDLE, DATA, PARITY, STOP, DONE.
  - IDLE: on fall with dat=0, go to DATA with bit_cnt=0. On fall with dat=1, stay in IDLE (spurious start, ignored).
  - DATA: on each fall, shift the byte right with msb<=dat, so bits arrive LSB first. On the 8th fall, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, go to DONE with frame_ok=dat and par_ok=^{byte,parity}.
  - DONE: one cycle, then always IDLE.
- DONE decode, in priority order:
  - !par_ok or !frame_ok: emit {code=byte, brk=pend_brk, ext=pend_ext, parity_err=!par_ok, frame_err=!frame_ok}, then clear both pending flags.
  - byte=E0: set pend_ext; no emit.
  - byte=F0: set pend_brk; no emit.
  - otherwise: emit {code=byte, brk=pend_brk, ext=pend_ext, errs=0} and clear both pending flags.
- Emit: code_word[14:0] is registered and held until the next emit. code_word[15] and code_valid are high for exactly one cycle, the cycle after DONE.
- Latency: fall of the stop bit registered in cycle N; DONE in N+1; code_valid=1 in N+2.
- Timeout:
  - A counter runs in DATA, PARITY and STOP, clears on every fall, and is held at 0 in IDLE.
  - At TIMEOUT_CYC-1 the block emits code=0x00 with frame_err=1, brk/ext from the pending flags, clears the pending flags and goes to IDLE.
- enable=0: the next state is IDLE and the pending flags and counters clear. No emit occurs, and a DONE in the same cycle is suppressed. The filters keep running.
- Precedence: reset over enable, enable over timeout, timeout over fall.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- The block never drives the PS/2 lines (receive-only).

Test Plan:
1. Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), 10 kHz PS/2 clock, FILTER_LEN=8 -> one code_valid pulse 2 cycles after the stop-bit filtered fall; code_word=0x801C during the pulse, then holds 0x001C; busy low afterwards.
2. Sequences F0,1C and E0,F0,75 -> exactly one emit each: 0x011C, then 0x0375; no pulses for the prefix bytes.
3. Error frames:
   - 0x1C with parity bit 1 after prefix F0 -> 0x051C; pending flags cleared, so a following clean 0x1C gives 0x001C.
   - Stop bit 0 -> 0x081C.
4. Bench TIMEOUT_CYC=1000; clocks stop after 4 data bits -> emit 0x0800 exactly 1000 cycles after the last fall; busy drops the same cycle as state IDLE.
5. Robustness, each followed by a clean 0x1C frame that must decode correctly:
   - 3-cycle low glitch on ps2_clk while idle -> busy stays 0, no emit.
   - enable=0 for 1 cycle after 5 data bits -> IDLE, no emit.
6. reset asserted mid-DATA -> all outputs 0 the next cycle.
